// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 16-bit data memory.
// Each access runs IDLE -> ACCESS -> RESP; read data is registered per port.
module data_mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              pick;
    logic [DATA_W-1:0] rd_val;

    assign in_range = (addr_q[ADDR_W-1:DEPTH_W] == '0);
    assign rd_val   = (in_range && !we_q) ? mem_read_data : '0;
    // A lone requester wins; under contention the port not served last wins
    assign pick     = (req0 && req1) ? ~last_grant_q : req1;

    // State register and latched access fields; port 0 favoured after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err_q        <= err_d;
        end
    end

    // Next-state: each active state lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latch in IDLE, read capture in ACCESS, fairness update in RESP
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                err_d = ~in_range;
                if (gnt_q) rdata1_d = rd_val;
                else       rdata0_d = rd_val;
            end
            RESP:    last_grant_d = gnt_q;
            default: ;
        endcase
    end

    // Outputs decoded from registered state; memory strobes only in ACCESS
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        ack0            = 1'b0;
        ack1            = 1'b0;
        err0            = 1'b0;
        err1            = 1'b0;
        unique case (state_q)
            ACCESS: begin
                mem_access_addr = addr_q;
                mem_write_data  = wdata_q;
                mem_write_en    = in_range && we_q;
                mem_read        = in_range && !we_q;
            end
            RESP: begin
                ack0 = ~gnt_q;
                ack1 = gnt_q;
                err0 = ~gnt_q & err_q;
                err1 = gnt_q & err_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-port 16-bit data memory.
- Port 0 is the processor datapath; port 1 is the loader/debug master.
- Each requester gets a req/ack handshake with registered read data, so the memory's combinational read path never reaches a requester directly.
- Out-of-range addresses are detected and suppressed.

Parameters:
- DATA_W, 16, data word width (matches memory column width).
- ADDR_W, 16, requester and memory address width.
- DEPTH_W, 3, number of address bits the memory decodes (8 words).

Ports:
- clk  in  1  system clock, all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port 0 access type: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data; valid while ack0=1.
- err0  out  1  port 0 out-of-range flag; valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1.
- mem_access_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_write_en  out  1  memory write strobe.
- mem_read  out  1  memory read enable.
- mem_read_data  in  DATA_W  memory combinational read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE; all ack*, err*, mem_write_en, mem_read and busy = 0; rdata*, mem_access_addr and mem_write_data = 0; last_grant=1, so port 0 wins the first contention.
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - Latch the granted port id, we, addr and wdata into internal registers, then go to ACCESS.
- ACCESS:
  - Drive mem_access_addr and mem_write_data from the latched values.
  - Range check: in range when addr[ADDR_W-1:DEPTH_W]==0.
  - In-range write: mem_write_en=1, mem_read=0. The memory commits at the edge ending ACCESS.
  - In-range read: mem_read=1, mem_write_en=0. Capture mem_read_data into the granted port's rdata register at the edge ending ACCESS.
  - Out of range: mem_write_en=0, mem_read=0, rdata captured as 0, err flag set for the RESP cycle.
  - Then go to RESP.
- RESP:
  - ack of the granted port = 1 for exactly this cycle; its err is valid this cycle.
  - Update last_grant to the granted port; go to IDLE.
- Output timing: memory control outputs are decoded from registered state and latched fields. They are 0 in every state other than ACCESS.
- Latency: request sampled at edge N → ack high in cycle N+2 → next grant sampled at edge N+3 at the earliest.
- Peak throughput is 1 access per 3 cycles.
- Handshake rules:
  - The requester deasserts req, or presents a new request, on the edge on which it samples ack.
  - A req still high in IDLE is a new request.
  - A non-granted req stays pending and is not acknowledged.
  - Fairness: under continuous contention, grants strictly alternate.
- Output hold behaviour:
  - rdataN holds its last value until that port's next read completes.
  - rdataN is written with 0 on that port's out-of-range read and on writes.
  - errN is cleared outside RESP.
- Reset mid-operation: asserting reset in ACCESS drops mem_write_en immediately (asynchronous), so no write is guaranteed. No ack is issued, and the state returns to IDLE.
- Simultaneous events: a new req arriving during ACCESS/RESP is not sampled until IDLE. A req0/req1 change during ACCESS has no effect on the latched access.

Test Plan:
- Reset, then req0 write addr=5, wdata=16'hA5A5 → mem_write_en=1 with mem_access_addr=5 for one cycle, ack0 two cycles after the request edge. Then req0 read addr=5 → rdata0=16'hA5A5, err0=0.
- req0 and req1 reads raised on the same edge after reset, held → port 0 acked first, port 1 acked 3 cycles later. Repeated 4 times continuously, grants alternate 0,1,0,1.
- req1 write addr=16'h0008, wdata=16'hFFFF → mem_write_en stays 0, ack1 with err1=1. Memory word 0 unchanged on readback.
- Only req1 asserted for 3 back-to-back transactions → each granted, ack1 every 3 cycles, ack0 never asserted.
- Assert reset in ACCESS of a write to addr 2 → mem_write_en falls immediately, no ack, busy=0, all outputs at reset values. After release, the first grant goes to port 0.
- Port 0 read addr=7 completes, then port 1 write addr=7 → rdata0 keeps the old value and is unaffected by port 1 activity.
